// File: rtl/cfc_sequencer.sv
// cfc_sequencer: drives a four-lane MAC coprocessor through one
// 3x3 convolution pass (RESET, 36 tap-major MULs, GET).
module cfc_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        win_we,
  input  logic [3:0]  win_addr,
  input  logic [7:0]  win_data,
  input  logic        coef_we,
  input  logic [5:0]  coef_addr,
  input  logic [7:0]  coef_data,
  output logic [1:0]  cmd_op,
  output logic [1:0]  cmd_index,
  output logic [7:0]  cmd_a,
  output logic [7:0]  cmd_b,
  input  logic        cmd_done,
  input  logic [31:0] cmd_data,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RST = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_GET = 2'd3;

  localparam logic [5:0] T_LAST = 6'd37;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_e;

  state_e          state, state_nx;
  logic [5:0]      t, t_nx;
  logic [TW-1:0]   wait_cnt, wait_nx;
  logic            error_nx;
  logic [31:0]     result_nx;

  logic [7:0]      pix  [9];
  logic [7:0]      coef [4][9];

  logic [5:0]      m;
  logic [3:0]      tap;
  logic [1:0]      lane;
  logic            wr_ok;

  assign busy         = (state != IDLE);
  assign result_valid = (state == FINISH);
  assign wr_ok        = (state == IDLE);

  // MUL number m = t-1 splits into tap (outer) and lane (inner)
  assign m    = t - 6'd1;
  assign tap  = m[5:2];
  assign lane = m[1:0];

  // Operand storage; only writable while idle, taps 9..15 dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 9; k++) begin
        pix[k] <= '0;
        for (int l = 0; l < 4; l++) coef[l][k] <= '0;
      end
    end else if (wr_ok) begin
      if (win_we && win_addr < 4'd9)
        pix[win_addr] <= win_data;
      if (coef_we && coef_addr[3:0] < 4'd9)
        coef[coef_addr[5:4]][coef_addr[3:0]] <= coef_data;
    end
  end

  // Command bus: operands follow t through ISSUE and WAIT
  always_comb begin
    cmd_op    = OP_NOP;
    cmd_index = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    if (state == ISSUE || state == WAIT) begin
      unique case (1'b1)
        (t == 6'd0): begin
          if (state == ISSUE) cmd_op = OP_RST;
        end
        (t == T_LAST): begin
          if (state == ISSUE) cmd_op = OP_GET;
        end
        default: begin
          if (state == ISSUE) cmd_op = OP_MUL;
          cmd_index = lane;
          cmd_a     = pix[tap];
          cmd_b     = coef[lane][tap];
        end
      endcase
    end
  end

  // Sequencing, completion capture and WAIT timeout
  always_comb begin
    state_nx  = state;
    t_nx      = t;
    wait_nx   = wait_cnt;
    error_nx  = error;
    result_nx = result;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          t_nx     = '0;
          error_nx = 1'b0;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
        wait_nx  = '0;
      end
      WAIT: begin
        if (cmd_done) begin
          if (t == T_LAST) begin
            result_nx = cmd_data;
            state_nx  = FINISH;
          end else begin
            t_nx     = t + 6'd1;
            state_nx = ISSUE;
          end
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          error_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      t        <= '0;
      wait_cnt <= '0;
      error    <= 1'b0;
      result   <= '0;
    end else begin
      state    <= state_nx;
      t        <= t_nx;
      wait_cnt <= wait_nx;
      error    <= error_nx;
      result   <= result_nx;
    end
  end

endmodule

// File: tb/tb_cfc_sequencer.sv
// tb_cfc_sequencer: scoreboard bench with a 2-cycle MAC
// coprocessor model driving cfc_sequencer through directed passes.
module tb_cfc_sequencer;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        win_we = 1'b0;
  logic [3:0]  win_addr = '0;
  logic [7:0]  win_data = '0;
  logic        coef_we = 1'b0;
  logic [5:0]  coef_addr = '0;
  logic [7:0]  coef_data = '0;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_index;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        cmd_done = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        error;

  cfc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .win_we(win_we), .win_addr(win_addr), .win_data(win_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .cmd_op(cmd_op), .cmd_index(cmd_index),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_done(cmd_done), .cmd_data(cmd_data),
    .busy(busy), .result(result),
    .result_valid(result_valid), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [1:0] op;
    logic [1:0] idx;
    logic [7:0] a;
    logic [7:0] b;
  } tx_t;

  tx_t        exp_q[$];
  logic [7:0] sh_pix  [9];
  logic [7:0] sh_coef [4][9];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc;
  int         acc [4];
  int         cp_cnt, cp_tx;
  bit         cp_arm;
  bit         pw_en = 0;
  logic [3:0] pw_addr;
  logic [7:0] pw_data;

  task automatic write_win(input int k, input logic [7:0] d);
    @(posedge clock); #1;
    win_we = 1; win_addr = 4'(k); win_data = d;
    sh_pix[k] = d;
    @(posedge clock); #1;
    win_we = 0;
  endtask

  task automatic write_coef(input int l, input int k,
                            input logic [7:0] d);
    @(posedge clock); #1;
    coef_we = 1; coef_addr = {2'(l), 4'(k)}; coef_data = d;
    sh_coef[l][k] = d;
    @(posedge clock); #1;
    coef_we = 0;
  endtask

  task automatic clear_shadow();
    for (int k = 0; k < 9; k++) begin
      sh_pix[k] = '0;
      for (int l = 0; l < 4; l++) sh_coef[l][k] = '0;
    end
  endtask

  // One pass: scoreboard of 38 issues, coprocessor model, hooks
  task automatic run_pass(input int skip_t, input int stray_c,
                          input int rs_c, input int wr_c,
                          input int abort_c,
                          input logic [31:0] exp_res);
    int  err_c, nvalid;
    bit  ended;
    tx_t e;
    if (pw_en) sh_pix[pw_addr] = pw_data;
    exp_q.delete();
    for (int t = 0; t < 38; t++) begin
      e.cyc = 1 + 3 * t;
      e.idx = '0; e.a = '0; e.b = '0;
      if (t == 0) e.op = 2'd1;
      else if (t == 37) e.op = 2'd3;
      else begin
        e.op  = 2'd2;
        e.idx = 2'((t - 1) % 4);
        e.a   = sh_pix[(t - 1) / 4];
        e.b   = sh_coef[(t - 1) % 4][(t - 1) / 4];
      end
      exp_q.push_back(e);
    end
    err_c = (skip_t >= 0) ? 3 * skip_t + TIMEOUT + 2 : -10;
    cp_arm = 0; cp_tx = 0; nvalid = 0; ended = 0;
    for (int l = 0; l < 4; l++) acc[l] = 0;
    cmd_data = '0;
    @(posedge clock); #1;
    cyc = 0; start = 1;
    if (pw_en) begin
      win_we = 1; win_addr = pw_addr; win_data = pw_data;
    end
    pw_en = 0;
    @(negedge clock);
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      cyc++;
      start  = (rs_c > 0 && (cyc == rs_c || cyc == rs_c + 45));
      win_we = (cyc == wr_c);
      win_addr = '0; win_data = 8'h55;
      if (cyc == abort_c) begin
        reset_n = 0; cmd_done = 0;
        #1;
        n_chk++;
        if ({cmd_op, cmd_index, cmd_a, cmd_b, result,
             result_valid, busy, error} !== '0)
          $display("FAIL abort_zero: op=%0d idx=%0d a=%h b=%h res=%h rv=%b busy=%b err=%b, want all 0",
                   cmd_op, cmd_index, cmd_a, cmd_b, result,
                   result_valid, busy, error);
        else n_pass++;
        clear_shadow();
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1;
        nvalid = 0;
        for (int j = 0; j < 130; j++) begin
          @(negedge clock);
          if (result_valid || busy) nvalid++;
        end
        n_chk++;
        if (nvalid !== 0)
          $display("FAIL abort_idle: %0d active cycles, want 0", nvalid);
        else n_pass++;
        ended = 1;
        break;
      end
      cmd_done = 0;
      if (cp_arm) begin
        cp_cnt--;
        if (cp_cnt == 0) begin cmd_done = 1; cp_arm = 0; end
      end
      if (cyc == stray_c) cmd_done = 1;
      @(negedge clock);
      if (cmd_op != 2'd0) begin
        n_chk++;
        if (exp_q.size() == 0)
          $display("FAIL tx_extra: op=%0d at cyc %0d, want none",
                   cmd_op, cyc);
        else begin
          e = exp_q.pop_front();
          if (cmd_op !== e.op || cmd_index !== e.idx ||
              cmd_a !== e.a || cmd_b !== e.b || cyc != e.cyc)
            $display("FAIL tx_%0d: op=%0d idx=%0d a=%h b=%h cyc=%0d, want op=%0d idx=%0d a=%h b=%h cyc=%0d",
                     cp_tx, cmd_op, cmd_index, cmd_a, cmd_b, cyc,
                     e.op, e.idx, e.a, e.b, e.cyc);
          else n_pass++;
        end
        if (cmd_op == 2'd1)
          for (int l = 0; l < 4; l++) acc[l] = 0;
        if (cmd_op == 2'd2)
          acc[cmd_index] += int'(cmd_a) * int'($signed(cmd_b));
        cmd_data = {acc[3][7:0], acc[2][7:0],
                    acc[1][7:0], acc[0][7:0]};
        if (cp_tx != skip_t) begin cp_arm = 1; cp_cnt = 2; end
        cp_tx++;
      end
      if (cyc == 1) begin
        n_chk++;
        if (error !== 1'b0 || busy !== 1'b1)
          $display("FAIL start_accept: err=%b busy=%b, want 0 1",
                   error, busy);
        else n_pass++;
      end
      if (result_valid) begin
        nvalid++;
        n_chk++;
        if (cyc != 115 || result !== exp_res || exp_q.size() != 0)
          $display("FAIL result: cyc=%0d res=%h left=%0d, want cyc=115 res=%h left=0",
                   cyc, result, exp_q.size(), exp_res);
        else n_pass++;
      end
      if (cyc == err_c - 1) begin
        n_chk++;
        if (error !== 1'b0 || busy !== 1'b1)
          $display("FAIL pre_timeout: err=%b busy=%b, want 0 1",
                   error, busy);
        else n_pass++;
      end
      if (cyc == err_c) begin
        n_chk++;
        if (error !== 1'b1 || busy !== 1'b0)
          $display("FAIL timeout: err=%b busy=%b, want 1 0",
                   error, busy);
        else n_pass++;
      end
      if (!busy) begin ended = 1; break; end
    end
    start = 0; win_we = 0; cmd_done = 0;
    if (!ended) begin
      n_chk++;
      $display("FAIL pass_bound: still busy at cyc %0d, want idle",
               cyc);
    end else if (abort_c < 0) begin
      n_chk++;
      if (skip_t < 0 && nvalid != 1)
        $display("FAIL valid_count: got %0d pulses, want 1", nvalid);
      else if (skip_t >= 0 &&
               (nvalid != 0 || exp_q.size() != 37 - skip_t))
        $display("FAIL timeout_tail: pulses=%0d left=%0d, want 0 %0d",
                 nvalid, exp_q.size(), 37 - skip_t);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    clear_shadow();
    repeat (3) @(negedge clock);
    n_chk++;
    if ({cmd_op, cmd_index, cmd_a, cmd_b, result,
         result_valid, busy, error} !== '0)
      $display("FAIL reset_hold: op=%0d a=%h b=%h res=%h busy=%b err=%b, want all 0",
               cmd_op, cmd_a, cmd_b, result, busy, error);
    else n_pass++;
    @(posedge clock); #1;
    reset_n = 1;
    repeat (2) @(negedge clock);
    n_chk++;
    if (busy !== 1'b0 || cmd_op !== 2'd0 || result_valid !== 1'b0)
      $display("FAIL reset_idle: busy=%b op=%0d rv=%b, want 0 0 0",
               busy, cmd_op, result_valid);
    else n_pass++;
  endtask

  task automatic test_full_pass();
    for (int k = 0; k < 9; k++) write_win(k, 8'd1);
    for (int k = 0; k < 9; k++)
      for (int l = 0; l < 4; l++) write_coef(l, k, 8'(l + 1));
    run_pass(-1, -1, -1, -1, -1, 32'h241B_1209);
  endtask

  task automatic test_signed();
    write_coef(2, 4, 8'hFD);
    pw_en = 1; pw_addr = 4'd4; pw_data = 8'd200;
    run_pass(-1, -1, -1, -1, -1, 32'h40C0_A0D0);
    write_win(4, 8'd1);
    write_coef(2, 4, 8'd3);
  endtask

  task automatic test_timeout();
    run_pass(5, -1, -1, -1, -1, 32'h0);
    repeat (3) @(negedge clock);
    n_chk++;
    if (error !== 1'b1 || busy !== 1'b0 || result !== 32'h40C0_A0D0)
      $display("FAIL err_sticky: err=%b busy=%b res=%h, want 1 0 40c0a0d0",
               error, busy, result);
    else n_pass++;
  endtask

  task automatic test_write_busy();
    run_pass(-1, -1, -1, 10, -1, 32'h241B_1209);
    run_pass(-1, -1, -1, -1, -1, 32'h241B_1209);
  endtask

  task automatic test_back_to_back();
    run_pass(-1, 4, 5, -1, -1, 32'h241B_1209);
  endtask

  task automatic test_reset_mid();
    run_pass(-1, -1, -1, -1, 50, 32'h0);
    run_pass(-1, -1, -1, -1, -1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_signed();
    test_timeout();
    test_write_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cfc_sequencer.md
CFC_SEQUENCER -- requirements
Module: cfc_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clock (rising edge) and reset_n (active-low, asynchronous).
REQ-002 SHALL have parameter TIMEOUT, default 16: the number of WAIT cycles allowed without cmd_done before an error is raised.
REQ-003 clock  input  1  system clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin one 3x3 four-lane convolution pass; honoured in IDLE only.
REQ-006 win_we  input  1  pixel-window write strobe.
REQ-007 win_addr  input  4  tap index 0..8; values 9..15 are ignored.
REQ-008 win_data  input  8  unsigned pixel value.
REQ-009 coef_we  input  1  coefficient write strobe.
REQ-010 coef_addr  input  6  {lane[1:0], tap[3:0]}; tap values 9..15 are ignored.
REQ-011 coef_data  input  8  signed coefficient.
REQ-012 cmd_op  output  2  command to the coprocessor: 0 NOP, 1 RESET, 2 MUL, 3 GET.
REQ-013 cmd_index  output  2  MAC lane select.
REQ-014 cmd_a  output  8  unsigned pixel operand.
REQ-015 cmd_b  output  8  signed coefficient operand.
REQ-016 cmd_done  input  1  coprocessor completion pulse.
REQ-017 cmd_data  input  32  coprocessor packed result {lane3, lane2, lane1, lane0}.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 result  output  32  captured cmd_data from the last completed GET.
REQ-020 result_valid  output  1  one-cycle pulse when result updates.
REQ-021 error  output  1  sticky timeout flag; cleared by an accepted start or by reset.

Function
REQ-022 SHALL hold a 9 x 8-bit pixel window and a 4 x 9 x 8-bit coefficient bank in registers, writable only while busy=0; writes while busy=1 are ignored.
REQ-023 SHALL implement the states IDLE, ISSUE, WAIT and FINISH.
REQ-024 SHALL execute a 38-transaction sequence per pass, in this order:
- t=0: RESET.
- t=1..36: MUL, tap-major order (tap k = 0..8 outer loop, lane = 0..3 inner loop), with cmd_index=lane, cmd_a=pixel[k], cmd_b=coef[lane][k].
- t=37: GET.
REQ-025 IDLE: cmd_op=NOP; on start go to ISSUE at t=0 and clear error.
REQ-026 ISSUE: lasts exactly one cycle; cmd_op, cmd_index, cmd_a and cmd_b are driven for transaction t; next state is WAIT.
REQ-027 WAIT: cmd_op=NOP; cmd_index, cmd_a and cmd_b are held.
- On cmd_done with t<37: t increments and the next state is ISSUE.
- On cmd_done with t=37: cmd_data is captured into result and the next state is FINISH.
REQ-028 FINISH: result_valid=1 for one cycle; next state is IDLE.
REQ-029 SHALL count WAIT cycles; if TIMEOUT consecutive WAIT cycles occur without cmd_done, error=1, result is unchanged, no result_valid is issued, and the next state is IDLE.
REQ-030 cmd_done sampled in IDLE, ISSUE or FINISH SHALL be ignored.
REQ-031 SHALL ignore start when busy=1; an in-flight pass is never restarted.
REQ-032 On a simultaneous win_we/coef_we and start in IDLE, the write SHALL complete and the pass SHALL use the new value.
REQ-033 Timing against a compliant coprocessor (done pulse two cycles after issue):
- Each transaction takes 3 cycles.
- With start sampled in cycle 0, transaction t issues in cycle 1+3t.
- GET issues in cycle 112; result_valid is high in cycle 115.
REQ-034 SHALL not modify cmd_data values: no sign extension, no saturation, and no reordering of lanes.

Reset
REQ-035 While reset_n=0 (asynchronously), SHALL force:
- state=IDLE, t=0, wait counter=0.
- cmd_op=NOP, cmd_index=0, cmd_a=0, cmd_b=0.
- result=0, result_valid=0, busy=0, error=0.
- pixel window and coefficient bank=0.
REQ-036 Reset asserted mid-pass SHALL abandon the pass with no result_valid; after release, the block waits in IDLE for start.

Verification
REQ-037 Bench SHALL cover these directed scenarios:
- Full pass: pixels all 1, coef[lane][k]=lane+1, coprocessor model with 2-cycle done -> RESET, 36 MULs in tap-major order, GET; result_valid in cycle 115; result=0x24_1B_12_09.
- Signed operand: coef[2][4]=-3 (0xFD), pixel[4]=200 -> the MUL at t=19 drives cmd_index=2, cmd_a=0xC8, cmd_b=0xFD.
- Timeout: model never asserts done for t=5 -> error=1 exactly TIMEOUT WAIT cycles after issue, busy=0, no result_valid; the next start clears error.
- Write while busy: win_we to tap 0 with 0x55 during a pass -> the window is unchanged; the next pass drives cmd_a=old value at t=1.
- Start while busy plus a stray cmd_done in ISSUE -> both are ignored; the sequence and timing are identical to the full-pass scenario.
- Reset at cycle 50 of a pass -> all outputs are zero immediately; the window reads 0; no result_valid.
